// File: rtl/pixie_framebuffer.sv
// Capture stage behind the CDP1861: packs serial video MSB-first into a LINES x BPL byte frame store
// with a registered read port for the scaler and a per-frame line count / done pulse.
module pixie_framebuffer #(
  parameter int LINES = 128,
  parameter int BPL   = 8,
  localparam int AW   = $clog2(LINES * BPL)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          pix_ce,
  input  logic          video,
  input  logic          HSync,
  input  logic          VSync,
  input  logic          line_active,
  input  logic          capture_en,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic          frame_done,
  output logic [7:0]    frame_lines
);

  localparam int LW = $clog2(LINES);
  localparam int BW = $clog2(BPL);
  localparam int CW = BW + 4;
  localparam logic [LW:0]   LINES_MAX = (LW + 1)'(LINES);
  localparam logic [CW-1:0] BITS_MAX  = CW'(BPL * 8);

  logic          hs_q;
  logic          vs_q;
  logic [CW-1:0] bit_cnt;
  logic [LW:0]   line_idx;
  logic          line_has_data;
  logic [6:0]    shift;
  logic [7:0]    mem [0:(1 << AW) - 1];

  logic          hs_fall;
  logic          vs_fall;
  logic          capture;
  logic          has_eff;
  logic          we;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic [LW+1:0] lines_sum;
  logic [LW:0]   lines_sat;

  assign hs_fall = hs_q & ~HSync;
  assign vs_fall = vs_q & ~VSync;
  assign capture = pix_ce && line_active && (line_idx < LINES_MAX) && (bit_cnt < BITS_MAX);

  // A strobe coincident with a sync fall still belongs to the line being closed.
  assign has_eff   = line_has_data | capture;
  assign lines_sum = {1'b0, line_idx} + (LW + 2)'(has_eff);
  assign lines_sat = (lines_sum > {1'b0, LINES_MAX}) ? LINES_MAX : lines_sum[LW:0];

  // Only seven history bits are held; the eighth bit of a byte is the live video sample.
  assign wr_data = {shift, video};
  assign wr_addr = {line_idx[LW-1:0], bit_cnt[BW+2:3]};
  assign we      = capture && (bit_cnt[2:0] == 3'd7) && capture_en;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      bit_cnt       <= '0;
      line_idx      <= '0;
      line_has_data <= 1'b0;
      shift         <= '0;
      frame_done    <= 1'b0;
      frame_lines   <= '0;
    end else begin
      hs_q       <= HSync;
      vs_q       <= VSync;
      frame_done <= 1'b0;
      if (capture) begin
        shift         <= {shift[5:0], video};
        bit_cnt       <= bit_cnt + 1'b1;
        line_has_data <= 1'b1;
      end
      if (vs_fall) begin
        frame_lines   <= 8'(lines_sat);
        frame_done    <= (lines_sat != '0);
        line_idx      <= '0;
        bit_cnt       <= '0;
        line_has_data <= 1'b0;
      end else if (hs_fall) begin
        bit_cnt <= '0;
        if (has_eff) begin
          if (line_idx != LINES_MAX) line_idx <= line_idx + 1'b1;
          line_has_data <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  // Nonblocking read of the same array gives read-before-write on an address collision.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) rd_data <= '0;
    else        rd_data <= mem[rd_addr];
  end

endmodule

// File: tb/tb_pixie_framebuffer.sv
// Directed bench for pixie_framebuffer: a line/frame level model predicts frame store contents,
// frame_lines and frame_done; a per-cycle compare process plus literal checks pin the model.
module tb_pixie_framebuffer;
  localparam int LINES = 128;
  localparam int BPL   = 8;
  localparam int AW    = 10;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          pix_ce = 1'b0;
  logic          video = 1'b0;
  logic          HSync = 1'b1;
  logic          VSync = 1'b1;
  logic          line_active = 1'b0;
  logic          capture_en = 1'b1;
  logic [AW-1:0] rd_addr = '0;
  logic [7:0]    rd_data;
  logic          frame_done;
  logic [7:0]    frame_lines;

  int checks = 0;
  int failures = 0;
  int done_count = 0;

  logic [7:0] line_buf [0:8];
  logic [7:0] model_mem [0:(1 << AW) - 1];
  bit         model_valid [0:(1 << AW) - 1];
  int         m_line = 0;
  bit         m_has = 1'b0;
  int         m_lines = 0;
  bit         m_done = 1'b0;

  pixie_framebuffer #(.LINES(LINES), .BPL(BPL)) dut (
    .clock(clock), .reset(reset), .pix_ce(pix_ce), .video(video),
    .HSync(HSync), .VSync(VSync), .line_active(line_active), .capture_en(capture_en),
    .rd_addr(rd_addr), .rd_data(rd_data), .frame_done(frame_done), .frame_lines(frame_lines)
  );

  always #5 clock = ~clock;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  always @(negedge clock) begin
    check_output("frame_done", frame_done, m_done);
    check_output("frame_lines", frame_lines, m_lines);
    if (frame_done) done_count++;
  end

  task automatic close_frame_model();
    int v;
    v = m_line + int'(m_has);
    if (v > LINES) v = LINES;
    m_lines = v;
    m_done  = (v != 0);
    m_line  = 0;
    m_has   = 1'b0;
  endtask

  // Drive nbits strobes back to back from line_buf; optionally drop both syncs on the last strobe.
  task automatic send_line(input int nbits, input bit sync_last);
    for (int i = 0; i < nbits; i++) begin
      @(posedge clock); #1;
      pix_ce      = 1'b1;
      line_active = 1'b1;
      video       = line_buf[i / 8][7 - (i % 8)];
      if (sync_last && i == nbits - 1) begin
        HSync = 1'b0;
        VSync = 1'b0;
      end
    end
    @(posedge clock); #1;
    pix_ce      = 1'b0;
    line_active = 1'b0;
    if (nbits > 0 && m_line < LINES) begin
      m_has = 1'b1;
      for (int j = 0; j < BPL; j++) begin
        if ((j + 1) * 8 <= nbits && capture_en) begin
          model_mem[m_line * BPL + j]   = line_buf[j];
          model_valid[m_line * BPL + j] = 1'b1;
        end
      end
    end
    if (sync_last) begin
      close_frame_model();
      HSync = 1'b1;
      VSync = 1'b1;
      @(posedge clock); #1;
      m_done = 1'b0;
    end
  endtask

  task automatic hsync_end();
    @(posedge clock); #1;
    HSync = 1'b0;
    @(posedge clock); #1;
    HSync = 1'b1;
    if (m_has) begin
      if (m_line < LINES) m_line++;
      m_has = 1'b0;
    end
  endtask

  task automatic vsync_end();
    @(posedge clock); #1;
    VSync = 1'b0;
    @(posedge clock); #1;
    close_frame_model();
    VSync = 1'b1;
    @(posedge clock); #1;
    m_done = 1'b0;
  endtask

  task automatic read_check(input string name, input int addr, input logic [7:0] expected);
    @(posedge clock); #1;
    rd_addr = AW'(addr);
    @(posedge clock); #1;
    check_output(name, rd_data, expected);
  endtask

  task automatic read_model(input int addr);
    if (model_valid[addr]) read_check("model_read", addr, model_mem[addr]);
  endtask

  task automatic apply_reset_with_strobes(input int cycles);
    @(posedge clock); #1;
    reset   = 1'b0;
    m_lines = 0;
    m_done  = 1'b0;
    m_line  = 0;
    m_has   = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clock); #1;
      pix_ce      = ~pix_ce;
      line_active = 1'b1;
      video       = i[0];
      check_output("reset_rd_data", rd_data, 8'h00);
    end
    pix_ce      = 1'b0;
    line_active = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [7:0] old_val;
    logic [7:0] one_line [0:7];
    one_line = '{8'hA5, 8'h3C, 8'h5A, 8'hC3, 8'h0F, 8'hF0, 8'h81, 8'h7E};
    for (int a = 0; a < (1 << AW); a++) model_valid[a] = 1'b0;

    apply_reset_with_strobes(10);
    vsync_end();
    check_output("empty_frame_lines", frame_lines, 8'd0);
    check_output("empty_frame_done_count", done_count, 0);

    // One line of a known pattern
    for (int j = 0; j < 8; j++) line_buf[j] = one_line[j];
    done_count = 0;
    send_line(64, 1'b0);
    hsync_end();
    vsync_end();
    check_output("one_line_frame_lines", frame_lines, 8'd1);
    check_output("one_line_done_pulses", done_count, 1);
    for (int a = 0; a < 8; a++) read_model(a);
    read_check("one_line_byte0", 0, 8'hA5);
    read_check("one_line_byte1", 1, 8'h3C);
    read_check("one_line_byte7", 7, 8'h7E);

    // Reset with strobes toggling must not disturb the frame store
    apply_reset_with_strobes(8);
    check_output("reset_frame_lines", frame_lines, 8'd0);
    read_check("after_reset_byte2", 2, 8'h5A);

    // Full frame of 130 lines, each filled with its line number
    for (int l = 0; l < 130; l++) begin
      for (int j = 0; j < 9; j++) line_buf[j] = 8'(l);
      send_line(64, 1'b0);
      hsync_end();
    end
    vsync_end();
    check_output("full_frame_lines", frame_lines, 8'd128);
    for (int a = 0; a < (1 << AW); a++) read_model(a);
    read_check("full_line0", 0, 8'd0);
    read_check("full_line1", 9, 8'd1);
    read_check("full_line127", 127 * 8 + 7, 8'd127);

    // Overrun line of 70 strobes then a 5-strobe partial line
    for (int j = 0; j < 9; j++) line_buf[j] = 8'h10 + 8'(j);
    send_line(70, 1'b0);
    hsync_end();
    for (int j = 0; j < 9; j++) line_buf[j] = 8'hFF;
    send_line(5, 1'b0);
    hsync_end();
    vsync_end();
    check_output("overrun_frame_lines", frame_lines, 8'd2);
    for (int a = 0; a < 16; a++) read_model(a);
    read_check("overrun_byte7", 7, 8'h17);
    read_check("partial_line_untouched", 8, 8'd1);
    read_check("overrun_no_spill", 16, 8'd2);

    // Capture disabled for a whole frame
    capture_en = 1'b0;
    for (int j = 0; j < 9; j++) line_buf[j] = 8'hEE;
    send_line(64, 1'b0);
    hsync_end();
    send_line(64, 1'b0);
    hsync_end();
    vsync_end();
    capture_en = 1'b1;
    check_output("gated_frame_lines", frame_lines, 8'd2);
    for (int a = 0; a < 16; a++) read_model(a);
    read_check("gated_byte0", 0, 8'h10);

    // Read and write of address 5 in the same cycle
    for (int j = 0; j < 9; j++) line_buf[j] = 8'h60 + 8'(j);
    old_val = model_mem[5];
    fork
      send_line(64, 1'b0);
      begin
        repeat (48) @(posedge clock);
        #1 rd_addr = AW'(5);
        @(posedge clock); #1;
        check_output("collision_old", rd_data, old_val);
        @(posedge clock); #1;
        check_output("collision_new", rd_data, 8'h65);
      end
    join
    hsync_end();
    vsync_end();
    check_output("collision_old_literal", old_val, 8'h15);

    // Three lines, the last closed by a simultaneous HSync and VSync fall
    for (int l = 0; l < 3; l++) begin
      for (int j = 0; j < 9; j++) line_buf[j] = 8'h90 + 8'(16 * l) + 8'(j);
      send_line(64, l == 2);
      if (l < 2) hsync_end();
    end
    check_output("corner_frame_lines", frame_lines, 8'd3);
    read_check("corner_last_byte_line2", 2 * 8 + 7, 8'hB7);
    for (int a = 0; a < 24; a++) read_model(a);
    for (int j = 0; j < 9; j++) line_buf[j] = 8'h42 + 8'(j);
    send_line(64, 1'b0);
    hsync_end();
    vsync_end();
    check_output("restart_frame_lines", frame_lines, 8'd1);
    read_check("restart_line0", 0, 8'h42);
    read_check("restart_line1_kept", 8, 8'hA0);

    repeat (3) @(posedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
